dispatch_queue_8wide: RTL and testbench
=======================================

# dispatch_queue_8wide

Bundle FIFO directly downstream of the 8-wide renamer. It captures each renamed 8-slot bundle, holds it until the ROB accepts it, and stamps every valid slot with a consecutive ROB index on the way out. Its `in_ready_o` feeds the renamer's allocate-enable, which keeps the renamer's one-cycle registered output from overrunning the queue. A branch-mispredict flush empties the queue and reloads the ROB tail.

## Interface
Parameters:
- `DEPTH`, 4 — bundle entries; power of two, ≥ 2
- `PHYS_W`, 7 — physical register tag width
- `ROB_W`, 7 — ROB index width; indices wrap mod 2^ROB_W

Ports:
- `clk`  in  1  — single clock
- `rst`  in  1  — reset; synchronous, active-high
- `in_valid_i`  in  8  — per-slot valid from the renamer (`rename_valid`)
- `in_rs1_i`, `in_rs2_i`, `in_rd_i`, `in_old_rd_i`  in  PHYS_W ×8 each  — renamed tags per slot
- `in_ready_o`  out  1  — queue can absorb a bundle arriving next cycle
- `out_valid_o`  out  1  — head bundle present
- `out_slot_valid_o`  out  8  — head bundle per-slot valid
- `out_rs1_o`, `out_rs2_o`, `out_rd_o`, `out_old_rd_o`  out  PHYS_W ×8 each  — head bundle tags
- `out_rob_idx_o`  out  ROB_W ×8  — ROB index per slot
- `rob_ready_i`  in  1  — ROB accepts the head bundle this cycle
- `flush_i`  in  1  — mispredict flush
- `flush_rob_tail_i`  in  ROB_W  — ROB tail to resume from after a flush
- `overflow_o`  out  1  — sticky error flag: a bundle arrived while the queue was full

## Operation
- Enqueue: if `in_valid_i != 0` and `flush_i` is low, write the bundle at `wr_ptr` and advance `wr_ptr`. All-zero bundles are never stored.
- `in_ready_o` = (count ≤ DEPTH−2). One entry of slack covers the renamer's registered output latency.
- Dequeue: when `out_valid_o && rob_ready_i`, advance `rd_ptr` and add popcount(`out_slot_valid_o`) to `rob_tail`, mod 2^ROB_W.
- `out_rob_idx_o[k]` = `rob_tail` + (number of valid slots below k). For invalid slots the value is don't-care and is driven as the same prefix value.
- Count update is +1 on enqueue, −1 on dequeue, and unchanged when both happen in the same cycle.
- Enqueue when count == DEPTH:
  - with a dequeue in the same cycle: accepted normally.
  - without a dequeue: the bundle is dropped and `overflow_o` is set. `overflow_o` clears only on `rst`.
- Flush has priority over everything in the same cycle:
  - count, `rd_ptr` and `wr_ptr` go to 0.
  - `rob_tail` is loaded with `flush_rob_tail_i`.
  - the incoming bundle is dropped and no dequeue is counted.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- When empty, every data output and `out_slot_valid_o` is driven to 0.

## Timing
- Reset values:
  - `out_valid_o` = 0, `out_slot_valid_o` = 0, all tag and index outputs = 0
  - `in_ready_o` = 1, `overflow_o` = 0
  - count, pointers and `rob_tail` = 0
- Reset asserted mid-operation discards every stored bundle on that edge.
- Latency: a bundle enqueued at edge N is visible on the outputs after edge N. There is no same-cycle bypass.
- Outputs are combinational reads of registered storage plus `rob_tail`. No output depends combinationally on `rob_ready_i`.
- Sustained throughput is one bundle per cycle when `rob_ready_i` is held high.
- `in_ready_o` depends only on registered count, so it has no combinational input paths.

## Structure
- `rename_pkg` holds:
  - `PHYS_W` and `ROB_W` constants
  - `renamed_uop_t` struct {`valid`, `rs1`, `rs2`, `rd`, `old_rd`}
  - `renamed_bundle_t` = `renamed_uop_t` [7:0]
- Storage is an array of `renamed_bundle_t`, not reset. Emptiness gates the outputs instead.
- One sub-module: `slot_prefix_count8` — 8-bit valid mask in, 8 exclusive prefix counts (4 bits each) plus total popcount out. It is used for both index stamping and the tail advance.

## Test plan
- Reset, then bundle `in_valid_i`=8'hFF with rd tags 32..39 at cycle 1, `rob_ready_i`=1 → after that edge `out_valid_o`=1 and `out_rob_idx_o`=0..7; next cycle `rob_tail`=8 and the queue is empty.
- Sparse bundle `in_valid_i`=8'b1010_0101 with `rob_tail`=5 → indices: slot0=5, slot2=6, slot5=7, slot7=8; after dequeue `rob_tail`=9.
- Hold `rob_ready_i`=0 and push 3 bundles → `in_ready_o` drops when count reaches 3; a 4th bundle fills the queue with `overflow_o`=0; a 5th without dequeue sets `overflow_o`=1 and count stays 4.
- Tail wrap: `rob_tail`=124, bundle 8'hFF → indices 124, 125, 126, 127, 0, 1, 2, 3; new tail is 4.
- Flush with queue count 3, `flush_rob_tail_i`=42, and a bundle on the input that cycle → next cycle `out_valid_o`=0 and count=0; the input is dropped; the next bundle gets slot-0 index 42.
- Full queue with simultaneous enqueue and dequeue → count stays 4, `overflow_o` stays 0, FIFO order is preserved.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types for the rename/dispatch boundary: one renamed uop and an 8-wide bundle of them.
package rename_pkg;

  localparam int unsigned PHYS_W = 7;
  localparam int unsigned ROB_W  = 7;

  typedef struct packed {
    logic              valid;
    logic [PHYS_W-1:0] rs1;
    logic [PHYS_W-1:0] rs2;
    logic [PHYS_W-1:0] rd;
    logic [PHYS_W-1:0] old_rd;
  } renamed_uop_t;

  typedef renamed_uop_t [7:0] renamed_bundle_t;

endpackage

// File: rtl/slot_prefix_count8.sv
// Exclusive prefix popcount over an 8-slot valid mask, plus the total popcount.
module slot_prefix_count8 (
  input  logic [7:0]      i_mask,
  output logic [7:0][3:0] o_prefix,
  output logic [3:0]      o_total
);

  logic [3:0] w_acc;

  always_comb begin
    w_acc    = 4'd0;
    o_prefix = '0;
    for (int k = 0; k < 8; k++) begin
      o_prefix[k] = w_acc;
      w_acc       = w_acc + {3'b000, i_mask[k]};
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/dispatch_queue_8wide.sv
// Bundle FIFO between the 8-wide renamer and the ROB; stamps consecutive ROB indices on dequeue.
module dispatch_queue_8wide #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PHYS_W = rename_pkg::PHYS_W,
  parameter int unsigned ROB_W  = rename_pkg::ROB_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_valid_i,
  input  logic [7:0][PHYS_W-1:0] in_rs1_i,
  input  logic [7:0][PHYS_W-1:0] in_rs2_i,
  input  logic [7:0][PHYS_W-1:0] in_rd_i,
  input  logic [7:0][PHYS_W-1:0] in_old_rd_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic [7:0]             out_slot_valid_o,
  output logic [7:0][PHYS_W-1:0] out_rs1_o,
  output logic [7:0][PHYS_W-1:0] out_rs2_o,
  output logic [7:0][PHYS_W-1:0] out_rd_o,
  output logic [7:0][PHYS_W-1:0] out_old_rd_o,
  output logic [7:0][ROB_W-1:0]  out_rob_idx_o,
  input  logic                   rob_ready_i,
  input  logic                   flush_i,
  input  logic [ROB_W-1:0]       flush_rob_tail_i,
  output logic                   overflow_o
);

  import rename_pkg::renamed_bundle_t;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Storage is not reset; emptiness gates every output instead.
  renamed_bundle_t r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ROB_W-1:0] r_rob_tail;
  logic             r_overflow;

  renamed_bundle_t w_in_bundle;
  renamed_bundle_t w_head;
  logic [7:0]      w_head_mask;
  logic [7:0][3:0] w_prefix;
  logic [3:0]      w_total;
  logic            w_empty;
  logic            w_full;
  logic            w_enq_req;
  logic            w_enq;
  logic            w_deq;
  logic            w_ovf;

  always_comb begin
    w_in_bundle = '0;
    for (int k = 0; k < 8; k++) begin
      w_in_bundle[k].valid  = in_valid_i[k];
      w_in_bundle[k].rs1    = in_rs1_i[k];
      w_in_bundle[k].rs2    = in_rs2_i[k];
      w_in_bundle[k].rd     = in_rd_i[k];
      w_in_bundle[k].old_rd = in_old_rd_i[k];
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_enq_req = (|in_valid_i) && !flush_i;
  assign w_deq     = !w_empty && rob_ready_i && !flush_i;
  // A full queue still accepts when the head leaves on the same edge.
  assign w_enq     = w_enq_req && (!w_full || w_deq);
  assign w_ovf     = w_enq_req && w_full && !w_deq;

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_head_mask = '0;
    for (int k = 0; k < 8; k++) begin
      w_head_mask[k] = w_head[k].valid & !w_empty;
    end
  end

  slot_prefix_count8 u_prefix (
    .i_mask   (w_head_mask),
    .o_prefix (w_prefix),
    .o_total  (w_total)
  );

  always_comb begin
    out_rs1_o     = '0;
    out_rs2_o     = '0;
    out_rd_o      = '0;
    out_old_rd_o  = '0;
    out_rob_idx_o = '0;
    if (!w_empty) begin
      for (int k = 0; k < 8; k++) begin
        out_rs1_o[k]     = w_head[k].rs1;
        out_rs2_o[k]     = w_head[k].rs2;
        out_rd_o[k]      = w_head[k].rd;
        out_old_rd_o[k]  = w_head[k].old_rd;
        out_rob_idx_o[k] = r_rob_tail + ROB_W'(w_prefix[k]);
      end
    end
  end

  assign out_valid_o      = !w_empty;
  assign out_slot_valid_o = w_head_mask;
  assign in_ready_o       = (r_count <= CNT_W'(DEPTH - 2));
  assign overflow_o       = r_overflow;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= w_in_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rob_tail <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rob_tail <= flush_rob_tail_i;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_rob_tail <= r_rob_tail + ROB_W'(w_total);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue_8wide.sv
// Scoreboard bench for dispatch_queue_8wide: directed bundles, monitor checks each dequeued bundle.
module tb_dispatch_queue_8wide;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_valid_i;
  logic [7:0][6:0]  in_rs1_i, in_rs2_i, in_rd_i, in_old_rd_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [7:0]       out_slot_valid_o;
  logic [7:0][6:0]  out_rs1_o, out_rs2_o, out_rd_o, out_old_rd_o;
  logic [7:0][6:0]  out_rob_idx_o;
  logic             rob_ready_i;
  logic             flush_i;
  logic [6:0]       flush_rob_tail_i;
  logic             overflow_o;

  always #5 clk = ~clk;

  dispatch_queue_8wide #(
    .DEPTH  (4),
    .PHYS_W (7),
    .ROB_W  (7)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid_i       (in_valid_i),
    .in_rs1_i         (in_rs1_i),
    .in_rs2_i         (in_rs2_i),
    .in_rd_i          (in_rd_i),
    .in_old_rd_i      (in_old_rd_i),
    .in_ready_o       (in_ready_o),
    .out_valid_o      (out_valid_o),
    .out_slot_valid_o (out_slot_valid_o),
    .out_rs1_o        (out_rs1_o),
    .out_rs2_o        (out_rs2_o),
    .out_rd_o         (out_rd_o),
    .out_old_rd_o     (out_old_rd_o),
    .out_rob_idx_o    (out_rob_idx_o),
    .rob_ready_i      (rob_ready_i),
    .flush_i          (flush_i),
    .flush_rob_tail_i (flush_rob_tail_i),
    .overflow_o       (overflow_o)
  );

  typedef struct packed {
    logic [7:0]      mask;
    logic [7:0][6:0] rd;
    logic [7:0][6:0] idx;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [6:0] m_tail = 7'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] mask, input logic [6:0] base);
    in_valid_i = mask;
    for (int k = 0; k < 8; k++) begin
      in_rd_i[k]     = base + 7'(k);
      in_rs1_i[k]    = 7'(k);
      in_rs2_i[k]    = 7'(k + 8);
      in_old_rd_i[k] = base + 7'(k + 64);
    end
  endtask

  // Reference: exclusive running count of valid slots added to the model tail.
  task automatic expect_bundle(input logic [7:0] mask, input logic [6:0] base);
    exp_t       e;
    logic [6:0] n;
    n = 7'd0;
    e.mask = mask;
    for (int k = 0; k < 8; k++) begin
      e.rd[k]  = base + 7'(k);
      e.idx[k] = m_tail + n;
      n        = n + {6'd0, mask[k]};
    end
    m_tail = m_tail + n;
    expq.push_back(e);
  endtask

  task automatic push(input logic [7:0] mask, input logic [6:0] base, input bit accept);
    drive(mask, base);
    if (accept) expect_bundle(mask, base);
    tick();
    in_valid_i = 8'h00;
  endtask

  task automatic do_flush(input logic [6:0] tail);
    flush_i          = 1'b1;
    flush_rob_tail_i = tail;
    tick();
    flush_i = 1'b0;
    in_valid_i = 8'h00;
    expq.delete();
    m_tail = tail;
  endtask

  task automatic drain_one;
    rob_ready_i = 1'b1;
    tick();
    rob_ready_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && !flush_i && out_valid_o && rob_ready_i) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dequeue: got mask %0h expected no bundle", out_slot_valid_o);
      end else begin
        mon_e = expq.pop_front();
        check("deq_mask", 64'(out_slot_valid_o), 64'(mon_e.mask));
        check("deq_rd", 64'(out_rd_o), 64'(mon_e.rd));
        check("deq_rob_idx", 64'(out_rob_idx_o), 64'(mon_e.idx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rob_ready_i = 1'b0; flush_i = 1'b0; flush_rob_tail_i = 7'd0;
    drive(8'h00, 7'd0);
    tick(); tick();
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_slot_valid", 64'(out_slot_valid_o), 64'd0);
    check("rst_rob_idx", 64'(out_rob_idx_o), 64'd0);
    check("rst_rd", 64'(out_rd_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    rst = 1'b0;

    // Full bundle, ROB ready: visible after one edge, gone after the next.
    rob_ready_i = 1'b1;
    push(8'hFF, 7'd32, 1'b1);
    check("t1_out_valid", 64'(out_valid_o), 64'd1);
    tick();
    rob_ready_i = 1'b0;
    check("t1_empty", 64'(out_valid_o), 64'd0);
    push(8'h01, 7'd50, 1'b1);
    check("t1_tail8", 64'(out_rob_idx_o[0]), 64'd8);
    drain_one();

    // Sparse bundle from tail 5.
    do_flush(7'd5);
    push(8'hA5, 7'd60, 1'b1);
    check("t2_idx0", 64'(out_rob_idx_o[0]), 64'd5);
    check("t2_idx2", 64'(out_rob_idx_o[2]), 64'd6);
    check("t2_idx5", 64'(out_rob_idx_o[5]), 64'd7);
    check("t2_idx7", 64'(out_rob_idx_o[7]), 64'd8);
    drain_one();
    push(8'h01, 7'd70, 1'b1);
    check("t2_tail9", 64'(out_rob_idx_o[0]), 64'd9);
    drain_one();

    // Fill with ROB stalled, then overflow.
    push(8'h11, 7'd80, 1'b1);
    check("t3_ready_c1", 64'(in_ready_o), 64'd1);
    push(8'h22, 7'd88, 1'b1);
    check("t3_ready_c2", 64'(in_ready_o), 64'd1);
    push(8'h33, 7'd96, 1'b1);
    check("t3_ready_c3", 64'(in_ready_o), 64'd0);
    push(8'h44, 7'd104, 1'b1);
    check("t3_ovf_full", 64'(overflow_o), 64'd0);
    push(8'h55, 7'd112, 1'b0);
    check("t3_ovf_set", 64'(overflow_o), 64'd1);
    check("t3_ready_full", 64'(in_ready_o), 64'd0);
    rob_ready_i = 1'b1;
    repeat (4) tick();
    rob_ready_i = 1'b0;
    check("t3_count4_empty", 64'(out_valid_o), 64'd0);

    // Reset mid-operation discards contents and clears overflow.
    push(8'h0F, 7'd10, 1'b1);
    push(8'hF0, 7'd20, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expq.delete();
    m_tail = 7'd0;
    check("rst_mid_valid", 64'(out_valid_o), 64'd0);
    check("rst_mid_ovf", 64'(overflow_o), 64'd0);
    check("rst_mid_ready", 64'(in_ready_o), 64'd1);

    // Tail wrap.
    do_flush(7'd124);
    push(8'hFF, 7'd30, 1'b1);
    check("t4_idx0", 64'(out_rob_idx_o[0]), 64'd124);
    check("t4_idx3", 64'(out_rob_idx_o[3]), 64'd127);
    check("t4_idx4", 64'(out_rob_idx_o[4]), 64'd0);
    check("t4_idx7", 64'(out_rob_idx_o[7]), 64'd3);
    drain_one();
    push(8'h01, 7'd40, 1'b1);
    check("t4_tail4", 64'(out_rob_idx_o[0]), 64'd4);
    drain_one();

    // Flush beats a concurrent enqueue.
    push(8'h81, 7'd1, 1'b1);
    push(8'h81, 7'd2, 1'b1);
    push(8'h81, 7'd3, 1'b1);
    drive(8'h3C, 7'd5);
    do_flush(7'd42);
    check("t5_flush_valid", 64'(out_valid_o), 64'd0);
    check("t5_flush_ready", 64'(in_ready_o), 64'd1);
    push(8'hFF, 7'd100, 1'b1);
    check("t5_idx42", 64'(out_rob_idx_o[0]), 64'd42);
    check("t5_mask", 64'(out_slot_valid_o), 64'hFF);
    drain_one();

    // Full queue with simultaneous enqueue and dequeue.
    push(8'h01, 7'd10, 1'b1);
    push(8'h03, 7'd20, 1'b1);
    push(8'h07, 7'd30, 1'b1);
    push(8'h0F, 7'd40, 1'b1);
    check("t6_full_ready", 64'(in_ready_o), 64'd0);
    rob_ready_i = 1'b1;
    push(8'h1F, 7'd50, 1'b1);
    check("t6_ovf_clear", 64'(overflow_o), 64'd0);
    check("t6_still_valid", 64'(out_valid_o), 64'd1);
    repeat (4) tick();
    rob_ready_i = 1'b0;
    check("t6_drained", 64'(out_valid_o), 64'd0);
    check("sb_empty", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
